// File: rtl/axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// axi_read_arbiter
//
// Shares one AXI read master port between NUM_MASTERS requesters (index 0 is
// the instruction side). Only one transaction is in flight at a time. Each
// request becomes either a BURST_LEN-beat INCR burst or a single beat. The
// AR payload is taken from a latch captured at grant time. R beats are routed
// back to the granted master only. err_proto is a sticky flag that records
// burst-length, ID and response errors.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  defined   : round-robin. The search starts after the
//                                   last grant.
//                       undefined : fixed priority. The highest index wins.
//
// Ports:
//   aclk, aresetn        clock; synchronous active-low reset
//   m_arvalid/m_araddr/m_burst   per-master request (address packed i*ADDR_W)
//   m_arready            per-master accept pulse (AR handshake cycle)
//   m_rdata              read data broadcast to all masters
//   m_rvalid/m_rlast     per-master beat/last, granted master only
//   ar*                  AXI AR channel (master side)
//   r*, rready           AXI R channel
//   err_proto            sticky protocol error
// ----------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_MASTERS-1:0]          m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_MASTERS-1:0]          m_burst,
  output logic [NUM_MASTERS-1:0]          m_arready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [NUM_MASTERS-1:0]          m_rlast,
  output logic [3:0]                      arid,
  output logic [ADDR_W-1:0]               araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic [1:0]                      arlock,
  output logic [3:0]                      arcache,
  output logic [2:0]                      arprot,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [3:0]                      rid,
  input  logic [DATA_W-1:0]               rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready,
  output logic                            err_proto
);

  // state  | meaning
  // S_IDLE | no transaction; arbitrate among m_arvalid
  // S_AR   | arvalid high with the latched payload; wait for arready
  // S_R    | rready high; forward beats to the granted master until rlast
  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  localparam int         GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0] ARLEN_BURST = 8'(BURST_LEN - 1);
  localparam logic [2:0] ARSIZE_C    = 3'($clog2(DATA_W / 8));

  state_t              state;
  logic [GW-1:0]       gnt_q;
  logic [GW-1:0]       gnt_sel;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_sel;
  logic [7:0]          len_q;
  logic                burst_q;
  logic [7:0]          beat_cnt;
  logic                arvalid_q;
  logic                rready_q;
  logic                err_q;
  logic                req_any;
  logic                beat_fire;
  logic                err_now;
  logic [NUM_MASTERS-1:0] gnt_oh;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]       gnt_ptr_q;

  // Walk the candidates from the far end of the search order back to the
  // nearest one, so the nearest requester is the last write and wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_sel = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = (int'(gnt_ptr_q) + 1 + i) % NUM_MASTERS;
      if (m_arvalid[idx]) gnt_sel = GW'(idx);
    end
  end
`else
  // Fixed priority: the highest requesting index is the last write and wins.
  always_comb begin
    gnt_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_arvalid[i]) gnt_sel = GW'(i);
    end
  end
`endif

  assign req_any  = |m_arvalid;
  assign addr_sel = m_araddr[int'(gnt_sel)*ADDR_W +: ADDR_W];

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt_oh[i] = (gnt_q == GW'(i));
    end
  end

  // Checks are applied to every accepted beat. The data is forwarded regardless.
  assign beat_fire = (state == S_R) && rvalid && rready_q;
  assign err_now   = beat_fire &&
                     (( rlast && (beat_cnt != len_q)) ||
                      (!rlast && (beat_cnt == len_q)) ||
                      (rid != 4'(gnt_q))               ||
                      (rresp != 2'b00));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= 1'b0;
      beat_cnt  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_ptr_q <= GW'(NUM_MASTERS - 1);
`endif
    end else begin
      if (err_now) err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            gnt_q     <= gnt_sel;
            addr_q    <= addr_sel;
            burst_q   <= m_burst[gnt_sel];
            len_q     <= m_burst[gnt_sel] ? ARLEN_BURST : 8'd0;
            arvalid_q <= 1'b1;
            state     <= S_AR;
`ifdef ARB_ROUND_ROBIN_EN
            gnt_ptr_q <= gnt_sel;
`endif
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_cnt  <= '0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (beat_fire) begin
            if (rlast) begin
              rready_q <= 1'b0;
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arvalid   = arvalid_q;
  assign arid      = 4'(gnt_q);
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = ARSIZE_C;
  assign arburst   = burst_q ? 2'b01 : 2'b00;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = 3'b000;
  assign rready    = rready_q;
  assign err_proto = err_q;

  assign m_arready = (arvalid_q && arready) ? gnt_oh : '0;
  assign m_rdata   = rdata;
  assign m_rvalid  = (state == S_R && rvalid) ? gnt_oh : '0;
  assign m_rlast   = (state == S_R && rvalid && rlast) ? gnt_oh : '0;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  m_arvalid;
  logic [63:0] m_araddr;
  logic [1:0]  m_burst;
  logic [1:0]  m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rlast;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        err_proto;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  axi_read_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .BURST_LEN(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_burst(m_burst),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .err_proto(err_proto)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts on a negedge one cycle after the request is driven.
  task automatic ar_accept(input int g, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] bt);
    int n;
    logic [1:0] oh;
    n  = 0;
    oh = 2'b01 << g;
    @(negedge aclk);
    while (arvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("ar_latency", n, 0);
    chk("arid", arid, g);
    chk("araddr", araddr, a);
    chk("arlen", arlen, len);
    chk("arburst", arburst, bt);
    chk("arsize", arsize, 3'd2);
    chk("ar_misc", {arlock, arcache, arprot}, 0);
    chk("m_arready_idle", m_arready, 0);
    arready = 1'b1;
    #1;
    chk("m_arready", m_arready, oh);
    @(negedge aclk);
    arready   = 1'b0;
    m_arvalid = 2'b00;
    chk("arvalid_drop", arvalid, 0);
  endtask

  // Drives beats starting at the current negedge. last_at < 0 means no rlast.
  task automatic r_beats(input int g, input int nbeats, input int last_at,
                         input logic [3:0] id, input logic [1:0] resp,
                         input logic [31:0] base);
    logic [1:0] oh;
    logic [31:0] e;
    oh = 2'b01 << g;
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rid    = id;
      rresp  = resp;
      rlast  = (b == last_at);
      exp_q.push_back(rdata);
      #1;
      chk("rready", rready, 1);
      chk("m_rvalid", m_rvalid, oh);
      chk("m_rlast", m_rlast, (b == last_at) ? oh : 2'b00);
      if (m_rvalid[g] === 1'b1) begin
        e = exp_q.pop_front();
        chk("m_rdata", m_rdata, e);
      end
      @(negedge aclk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    rvalid  = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int g;
    logic [31:0] a;
    m_arvalid = '0; m_araddr = '0; m_burst = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_m_rlast", m_rlast, 0);
    chk("rst_err", err_proto, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Master 0, 16-beat burst.
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h1FC0_0000; m_burst = 2'b01;
    ar_accept(0, 32'h1FC0_0000, 8'h0F, 2'b01);
    r_beats(0, 16, 15, 4'd0, 2'b00, 32'h0);
    chk("burst_err", err_proto, 0);
    chk("burst_queue", exp_q.size(), 0);

    // Master 1, single beat.
    m_arvalid = 2'b10; m_araddr[63:32] = 32'hBFAF_8000; m_burst = 2'b00;
    ar_accept(1, 32'hBFAF_8000, 8'h00, 2'b00);
    r_beats(1, 1, 0, 4'd1, 2'b00, 32'hCAFE_0001);
    chk("single_err", err_proto, 0);

    // Both masters request together, four times.
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = i % 2;
`else
      g = 1;
`endif
      m_arvalid = 2'b11;
      m_araddr  = {32'h2000_0000 + 32'(i*64), 32'h1000_0000 + 32'(i*64)};
      m_burst   = 2'b00;
      a = (g == 1) ? m_araddr[63:32] : m_araddr[31:0];
      ar_accept(g, a, 8'h00, 2'b00);
      r_beats(g, 1, 0, 4'(g), 2'b00, 32'h5A00_0000 + 32'(i));
    end
    chk("arb_err", err_proto, 0);

    // Early rlast on beat 8 of a burst: sticky error, FSM back in IDLE.
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h0000_4000; m_burst = 2'b01;
    ar_accept(0, 32'h0000_4000, 8'h0F, 2'b01);
    r_beats(0, 9, 8, 4'd0, 2'b00, 32'h100);
    chk("early_rlast_err", err_proto, 1);
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h0000_8000; m_burst = 2'b00;
    ar_accept(1, 32'h0000_8000, 8'h00, 2'b00);
    r_beats(1, 1, 0, 4'd1, 2'b00, 32'h200);
    chk("err_sticky", err_proto, 1);

    // Wrong rid on a grant-0 beat.
    do_reset();
    chk("err_cleared", err_proto, 0);
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h0000_C000; m_burst = 2'b00;
    ar_accept(0, 32'h0000_C000, 8'h00, 2'b00);
    r_beats(0, 1, 0, 4'd3, 2'b00, 32'h300);
    chk("bad_rid_err", err_proto, 1);

    // Non-OKAY response.
    do_reset();
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h0001_0000; m_burst = 2'b00;
    ar_accept(1, 32'h0001_0000, 8'h00, 2'b00);
    r_beats(1, 1, 0, 4'd1, 2'b10, 32'h400);
    chk("bad_resp_err", err_proto, 1);

    // Reset during beat 5 of a burst.
    do_reset();
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h0002_0000; m_burst = 2'b01;
    ar_accept(0, 32'h0002_0000, 8'h0F, 2'b01);
    r_beats(0, 5, -1, 4'd0, 2'b00, 32'h500);
    rvalid = 1'b1; rdata = 32'h505; aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1; rvalid = 1'b0;
    exp_q.delete();
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_rready", rready, 0);
    chk("midrst_err", err_proto, 0);
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h0003_0000; m_burst = 2'b01;
    ar_accept(0, 32'h0003_0000, 8'h0F, 2'b01);
    r_beats(0, 16, 15, 4'd0, 2'b00, 32'h600);
    chk("after_rst_err", err_proto, 0);
    chk("after_rst_rready", rready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Parametrised N-master AXI read-channel arbiter.
- Sits between the cache/uncached read requesters (icache, dcache, uncached unit, ...) and the single AXI master read port of the CPU core.
- Holds one outstanding transaction at a time and issues a 16-beat INCR burst or a single beat per request.
- Routes R beats back to the granted master, tagged by ARID, and flags burst-length/ID protocol errors.

Parameters:
NUM_MASTERS, 2, number of requesters (1..16); index 0 = instruction side.
ADDR_W, 32, address width.
DATA_W, 32, data width; ARSIZE = log2(DATA_W/8).
BURST_LEN, 16, beats per cached burst (1..256); ARLEN = BURST_LEN-1.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
m_arvalid  in  NUM_MASTERS  per-master read request
m_araddr  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W]
m_burst  in  NUM_MASTERS  1 = BURST_LEN-beat INCR, 0 = single-beat
m_arready  out  NUM_MASTERS  request accepted (one-cycle pulse)
m_rdata  out  DATA_W  read data, broadcast to all masters
m_rvalid  out  NUM_MASTERS  beat valid, granted master only
m_rlast  out  NUM_MASTERS  last beat, granted master only
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/ADDR_W/8/3/2/2/4/3/1  AXI AR
arready  in  1  AXI AR
rid/rdata/rresp/rlast/rvalid  in  4/DATA_W/2/1/1  AXI R
rready  out  1  AXI R
err_proto  out  1  sticky protocol-error flag

Behaviour:
- Reset (aresetn low at a rising edge):
  - State = IDLE; grant pointer = NUM_MASTERS-1.
  - Outputs zero: arvalid, rready, m_arready, m_rvalid, m_rlast, err_proto.
  - Reset mid-burst abandons the transaction; the AXI slave is reset in the same domain.
- FSM IDLE -> AR -> R -> IDLE.
- IDLE:
  - If any m_arvalid is set, choose grant g.
  - Latch m_araddr[g] and m_burst[g]; go to AR.
  - arvalid rises on the next cycle (1-cycle request latency).
- AR:
  - arvalid = 1; araddr = latched address; arid = g, zero-extended.
  - Burst request: arlen = BURST_LEN-1, arburst = 2'b01.
  - Single request: arlen = 0, arburst = 2'b00.
  - arsize = log2(DATA_W/8); arlock, arcache, arprot = 0.
  - On arvalid & arready: m_arready[g] pulses for that same cycle; go to R.
  - Master must hold m_arvalid, m_araddr and m_burst stable until m_arready.
  - The AR payload is from the latch and does not change while arvalid is high.
- R:
  - rready = 1; the master cannot stall.
  - m_rdata = rdata (combinational).
  - m_rvalid[g] = rvalid, m_rlast[g] = rlast; these are 0 for every other master.
  - An 8-bit beat counter increments on rvalid & rready.
  - On the rlast beat: go to IDLE and clear the counter.
  - Earliest next arvalid is 2 cycles after the rlast beat.
- err_proto sets (sticky until reset) on any of:
  - rlast with counter != latched arlen;
  - beat with counter == arlen and rlast = 0;
  - rvalid with rid != g;
  - rresp != 0.
  - Data is still forwarded when err_proto sets.
- Arbitration in IDLE only; no preemption.
  - A requester dropping m_arvalid before grant is legal.
  - Requests arriving during AR/R wait.
- No outstanding pipelining: a new AR is never issued before the current rlast.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. The search starts at (last grant + 1) mod NUM_MASTERS; the pointer updates on every grant.
- Undefined: fixed priority, highest index wins (data side over instruction side). The grant pointer is unused.

Test Plan:
- Single master 0, m_burst=1, addr 0x1FC0_0000; slave returns 16 beats 0x0..0xF -> arlen=0x0F, arburst=01, arid=0; m_rvalid[0] high for 16 beats; m_rlast[0] only on beat 0xF; err_proto=0.
- Master 1 single read of 0xBFAF_8000, m_burst=0 -> arlen=0, arburst=00, arid=1; one beat on m_rvalid[1]; m_rvalid[0] stays 0.
- Masters 0 and 1 request in the same cycle, repeated 4 times -> ARB_ROUND_ROBIN_EN: grants 0,1,0,1. Without the macro: master 1 is always granted first.
- Slave asserts rlast on beat 8 of a 16-beat burst -> err_proto=1 the following cycle and stays 1; FSM returns to IDLE.
- Wrong rid=3 on a grant-0 beat -> err_proto=1.
- aresetn low for 1 cycle during beat 5 of a burst -> next cycle arvalid=0, rready=0, state IDLE; a new request afterwards completes normally.
